// File: rtl/proc_bus_pkg.sv
// Shared constants and types for the processor datapath bus.
// Source indices follow the register file order, then G and DIN.
package proc_bus_pkg;

   localparam int BUS_WIDTH = 16;
   localparam int NSRC      = 10;

   localparam int SRC_R0  = 0;
   localparam int SRC_R1  = 1;
   localparam int SRC_R2  = 2;
   localparam int SRC_R3  = 3;
   localparam int SRC_R4  = 4;
   localparam int SRC_R5  = 5;
   localparam int SRC_R6  = 6;
   localparam int SRC_R7  = 7;
   localparam int SRC_G   = 8;
   localparam int SRC_DIN = 9;

   typedef logic [BUS_WIDTH-1:0] bus_word_t;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/onehot_prio_enc.sv
// Select-vector encoder: lowest set bit wins, multi flags
// more than one set bit.
module onehot_prio_enc #(
   parameter int N  = 10,
   parameter int IW = 4
) (
   input  logic [N-1:0]  sel,
   output logic          any,
   output logic [IW-1:0] idx,
   output logic          multi
);
   import proc_bus_pkg::*;

   localparam logic [N-1:0] ONE = 1;

   always_comb begin
      any   = |sel;
      multi = |(sel & (sel - ONE));
      idx   = '0;
      // scan downwards so the lowest set bit is written last
      for (int i = N - 1; i >= 0; i--) begin
         if (sel[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/bus_mux_reg.sv
// Registered one-hot bus multiplexer with conflict tracking.
// Define BUS_MUX_PARITY_EN to build the registered bus parity.
module bus_mux_reg #(
   parameter int WIDTH        = proc_bus_pkg::BUS_WIDTH,
   parameter int NSRC         = proc_bus_pkg::NSRC,
   parameter int CNT_W        = 8,
   parameter bit HOLD_ON_IDLE = 1'b1,
   localparam int SEL_W       = proc_bus_pkg::sel_width(NSRC)
) (
   input  logic                  Clock,
   input  logic                  Resetn,
   input  logic [NSRC*WIDTH-1:0] src_flat,
   input  logic [NSRC-1:0]       sel,
   input  logic                  err_clr,
   output logic [WIDTH-1:0]      Bus,
   output logic                  bus_valid,
   output logic [SEL_W-1:0]      bus_src,
   output logic                  conflict,
   output logic                  conflict_sticky,
   output logic [CNT_W-1:0]      conflict_cnt,
   output logic                  bus_par
);
   import proc_bus_pkg::*;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             any;
   logic             multi;
   logic [SEL_W-1:0] idx;
   logic [WIDTH-1:0] src_sel;

   logic [WIDTH-1:0] bus_d, bus_q;
   logic             valid_d, valid_q;
   logic [SEL_W-1:0] src_d, src_q;
   logic             conf_d, conf_q;
   logic             sticky_d, sticky_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   onehot_prio_enc #(
      .N  (NSRC),
      .IW (SEL_W)
   ) u_enc (
      .sel   (sel),
      .any   (any),
      .idx   (idx),
      .multi (multi)
   );

   always_comb begin
      src_sel = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (idx == SEL_W'(i)) src_sel = src_flat[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      bus_d = bus_q;
      if (any) begin
         bus_d = src_sel;
      end else if (!HOLD_ON_IDLE) begin
         bus_d = '0;
      end
      valid_d = any;
      src_d   = any ? idx : src_q;
      conf_d  = multi;
   end

   // a conflict on the same edge as err_clr is a new event and survives
   always_comb begin
      sticky_d = multi | (sticky_q & ~err_clr);
      cnt_d    = cnt_q;
      if (err_clr) begin
         cnt_d = multi ? CNT_W'(1) : '0;
      end else if (multi && cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         bus_q    <= '0;
         valid_q  <= 1'b0;
         src_q    <= '0;
         conf_q   <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         bus_q    <= bus_d;
         valid_q  <= valid_d;
         src_q    <= src_d;
         conf_q   <= conf_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef BUS_MUX_PARITY_EN
   logic par_d, par_q;

   // computed from bus_d so parity lines up with Bus on hold and clear
   always_comb begin
      par_d = ^bus_d;
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end

   assign bus_par = par_q;
`else
   assign bus_par = 1'b0;
`endif

   assign Bus             = bus_q;
   assign bus_valid       = valid_q;
   assign bus_src         = src_q;
   assign conflict        = conf_q;
   assign conflict_sticky = sticky_q;
   assign conflict_cnt    = cnt_q;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Scoreboard bench for bus_mux_reg: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_bus_mux_reg;
   import proc_bus_pkg::*;

   localparam int W    = 16;
   localparam int N    = 10;
   localparam int CW   = 4;
   localparam bit HOLD = 1'b1;

`ifdef BUS_MUX_PARITY_EN
   localparam bit PAR_ON = 1'b1;
`else
   localparam bit PAR_ON = 1'b0;
`endif

   logic            Clock = 1'b0;
   logic            Resetn = 1'b0;
   logic [N*W-1:0]  src_flat = '0;
   logic [N-1:0]    sel = '0;
   logic            err_clr = 1'b0;
   logic [W-1:0]    Bus;
   logic            bus_valid;
   logic [3:0]      bus_src;
   logic            conflict;
   logic            conflict_sticky;
   logic [CW-1:0]   conflict_cnt;
   logic            bus_par;

   bus_mux_reg #(
      .WIDTH        (W),
      .NSRC         (N),
      .CNT_W        (CW),
      .HOLD_ON_IDLE (HOLD)
   ) dut (
      .Clock           (Clock),
      .Resetn          (Resetn),
      .src_flat        (src_flat),
      .sel             (sel),
      .err_clr         (err_clr),
      .Bus             (Bus),
      .bus_valid       (bus_valid),
      .bus_src         (bus_src),
      .conflict        (conflict),
      .conflict_sticky (conflict_sticky),
      .conflict_cnt    (conflict_cnt),
      .bus_par         (bus_par)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [W-1:0]  bus;
      logic          valid;
      logic [3:0]    src;
      logic          conf;
      logic          sticky;
      logic [CW-1:0] cnt;
      logic          par;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_pass = 0;

   // reference state
   logic [W-1:0] m_bus;
   logic         m_valid;
   int           m_src;
   logic         m_conf;
   logic         m_sticky;
   int           m_cnt;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t",
                    nm, act, exp, $time);
   endtask

   task automatic model_reset();
      m_bus = '0; m_valid = 0; m_src = 0;
      m_conf = 0; m_sticky = 0; m_cnt = 0;
   endtask

   task automatic set_src(input int i, input logic [W-1:0] v);
      src_flat[i*W +: W] = v;
   endtask

   task automatic model_step();
      exp_t e;
      int   first;
      first = -1;
      for (int i = 0; i < N; i++) begin
         if (sel[i] && first < 0) first = i;
      end
      if (first >= 0) begin
         m_bus = src_flat[first*W +: W];
         m_src = first;
         m_valid = 1;
      end else begin
         m_valid = 0;
         if (!HOLD) m_bus = '0;
      end
      m_conf = $countones(sel) > 1;
      if (err_clr) begin
         m_sticky = m_conf;
         m_cnt = m_conf ? 1 : 0;
      end else if (m_conf) begin
         m_sticky = 1;
         if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
      e.bus = m_bus; e.valid = m_valid; e.src = 4'(m_src);
      e.conf = m_conf; e.sticky = m_sticky; e.cnt = CW'(m_cnt);
      e.par = PAR_ON ? ($countones(m_bus) % 2 == 1) : 1'b0;
      q.push_back(e);
   endtask

   task automatic cyc(input logic [N-1:0] s, input logic c);
      @(negedge Clock);
      sel = s;
      err_clr = c;
      @(posedge Clock);
      model_step();
      #2;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_bus"}, Bus, 0);
      chk({nm, "_valid"}, bus_valid, 0);
      chk({nm, "_src"}, bus_src, 0);
      chk({nm, "_conf"}, conflict, 0);
      chk({nm, "_sticky"}, conflict_sticky, 0);
      chk({nm, "_cnt"}, conflict_cnt, 0);
      chk({nm, "_par"}, bus_par, 0);
   endtask

   // monitor: one output per clock, compared against the queue head
   initial begin
      exp_t e;
      forever begin
         @(posedge Clock);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("mon_bus", Bus, e.bus);
            chk("mon_valid", bus_valid, e.valid);
            chk("mon_src", bus_src, e.src);
            chk("mon_conf", conflict, e.conf);
            chk("mon_sticky", conflict_sticky, e.sticky);
            chk("mon_cnt", conflict_cnt, e.cnt);
            chk("mon_par", bus_par, e.par);
         end
      end
   end

   initial begin
      logic [N-1:0] s;
      model_reset();
      #12;
      chk_zero("por");
      @(negedge Clock);
      Resetn = 1'b1;

      // load then asynchronous reset mid-cycle
      set_src(SRC_R2, 16'h1234);
      cyc(10'b0000000100, 1'b0);
      chk("t1_bus", Bus, 16'h1234);
      chk("t1_valid", bus_valid, 1);
      chk("t1_src", bus_src, 2);
      #1;
      sel = '0;
      Resetn = 1'b0;
      #1;
      chk_zero("t1_async");
      @(posedge Clock);
      #1;
      chk_zero("t1_held");
      @(negedge Clock);
      Resetn = 1'b1;
      model_reset();

      // conflict with priority result
      set_src(SRC_R1, 16'hBEEF);
      set_src(SRC_DIN, 16'h0001);
      cyc(10'b1000000010, 1'b0);
      chk("t2_bus", Bus, 16'hBEEF);
      chk("t2_src", bus_src, 1);
      chk("t2_conf", conflict, 1);
      chk("t2_sticky", conflict_sticky, 1);
      chk("t2_cnt", conflict_cnt, 1);
      cyc(10'b0000001000, 1'b0);
      chk("t2_conf_drop", conflict, 0);
      chk("t2_sticky_keep", conflict_sticky, 1);

      // idle behaviour
      set_src(SRC_R2, 16'h1234);
      cyc(10'b0000000100, 1'b0);
      repeat (3) cyc('0, 1'b0);
      chk("t3_bus", Bus, HOLD ? 16'h1234 : 16'h0000);
      chk("t3_valid", bus_valid, 0);

      // counter saturation and clear
      repeat (20) cyc(10'b0000000011, 1'b0);
      chk("t4_sat", conflict_cnt, 15);
      cyc(10'b0000000101, 1'b1);
      chk("t4_clr_conf_cnt", conflict_cnt, 1);
      chk("t4_clr_conf_sticky", conflict_sticky, 1);
      cyc('0, 1'b1);
      chk("t4_clr_cnt", conflict_cnt, 0);
      chk("t4_clr_sticky", conflict_sticky, 0);

      // parity
      set_src(SRC_R0, 16'h0007);
      cyc(10'b0000000001, 1'b0);
      chk("t5_par7", bus_par, PAR_ON);
      set_src(SRC_R0, 16'h0003);
      cyc(10'b0000000001, 1'b0);
      chk("t5_par3", bus_par, 0);

      // one-hot sweep
      for (int i = 0; i < N; i++) set_src(i, 16'hA000 + 16'(i));
      for (int i = 0; i < N; i++) begin
         s = '0;
         s[i] = 1'b1;
         cyc(s, 1'b0);
         chk("t6_bus", Bus, 16'hA000 + 16'(i));
         chk("t6_src", bus_src, i);
      end

      // randomized traffic
      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < N; i++) set_src(i, 16'($urandom));
         case ($urandom_range(0, 3))
            0: s = '0;
            1: begin
               s = '0;
               s[$urandom_range(0, N - 1)] = 1'b1;
            end
            default: s = N'($urandom);
         endcase
         cyc(s, $urandom_range(0, 7) == 0);
      end

      @(negedge Clock);
      sel = '0;
      err_clr = 1'b0;
      @(posedge Clock);
      model_step();
      #3;
      chk("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
